tlp_tx_arbiter: RTL

TLP_TX_ARBITER -- requirements
Module: tlp_tx_arbiter

---
 rtl/tlp_pkg.sv | 74 +++++++
 rtl/tlp_fc_credit_counter.sv | 61 ++++++
 rtl/tlp_tx_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tlp_pkg.sv
// ============================================================================
// Module   : tlp_pkg
// Purpose  : Shared definitions for the TLP transmit arbiter: TLP type
//            indices, FSM state encoding, credit counter widths and small
//            helper functions (data-credit need, round-robin pick).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlp_pkg;

  // TLP type indices (bit positions in every per-type vector)
  localparam int TLP_P     = 0;
  localparam int TLP_NP    = 1;
  localparam int TLP_CPL   = 2;
  localparam int NUM_TYPES = 3;

  // Credit counter widths
  localparam int HDR_CR_W  = 8;
  localparam int DAT_CR_W  = 12;

  // Request / return field widths
  localparam int LEN_W     = 10;  // payload length in DW
  localparam int RET_W     = 8;   // data credits returned per cycle
  localparam int NEED_W    = 9;   // data credits needed by one TLP (max 256)

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Data credits consumed by one TLP. A zero length with payload encodes
  // the maximum 1024 DW, i.e. 256 credits.
  function automatic logic [NEED_W-1:0] data_need(input logic            has_data,
                                                  input logic [LEN_W-1:0] len);
    logic [LEN_W:0] rounded;
    rounded = {1'b0, len} + (LEN_W+1)'(3);
    if (!has_data) begin
      return '0;
    end
    if (len == '0) begin
      return NEED_W'(256);
    end
    return rounded[LEN_W:2];
  endfunction

  // One-hot round-robin pick: search starts at the type after 'last'.
  function automatic logic [NUM_TYPES-1:0] rr_pick(input logic [NUM_TYPES-1:0] elig,
                                                   input logic [1:0]           last);
    logic [NUM_TYPES-1:0] g;
    g = '0;
    case (last)
      2'd0: begin
        if      (elig[TLP_NP])  g = 3'b010;
        else if (elig[TLP_CPL]) g = 3'b100;
        else if (elig[TLP_P])   g = 3'b001;
      end
      2'd1: begin
        if      (elig[TLP_CPL]) g = 3'b100;
        else if (elig[TLP_P])   g = 3'b001;
        else if (elig[TLP_NP])  g = 3'b010;
      end
      default: begin
        if      (elig[TLP_P])   g = 3'b001;
        else if (elig[TLP_NP])  g = 3'b010;
        else if (elig[TLP_CPL]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

endpackage : tlp_pkg

`default_nettype wire

// File: rtl/tlp_fc_credit_counter.sv
// ============================================================================
// Module   : tlp_fc_credit_counter
// Purpose  : Header and data flow-control credit counters for one TLP type.
//            Each cycle: cnt_next = cnt - debit + return, saturating at the
//            counter maximum. Debit never exceeds the count because the
//            arbiter only debits an eligible type.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            hdr_debit_i       - consume one header credit
//            hdr_ret_i         - one header credit returned
//            dat_debit_i       - data credits consumed
//            dat_ret_i         - data credits returned
//            hdr_cnt_o/dat_cnt_o - current credit counts
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlp_fc_credit_counter
  import tlp_pkg::*;
#(
  parameter int HDR_INIT = 32,
  parameter int DAT_INIT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hdr_debit_i,
  input  logic                hdr_ret_i,
  input  logic [NEED_W-1:0]   dat_debit_i,
  input  logic [RET_W-1:0]    dat_ret_i,
  output logic [HDR_CR_W-1:0] hdr_cnt_o,
  output logic [DAT_CR_W-1:0] dat_cnt_o
);

  logic [HDR_CR_W-1:0] hdr_cnt_q, hdr_cnt_d;
  logic [DAT_CR_W-1:0] dat_cnt_q, dat_cnt_d;
  logic [HDR_CR_W:0]   hdr_sum;
  logic [DAT_CR_W:0]   dat_sum;

  // One extra bit holds the overflow; underflow cannot occur.
  always_comb begin
    hdr_sum = {1'b0, hdr_cnt_q} - (HDR_CR_W+1)'(hdr_debit_i) + (HDR_CR_W+1)'(hdr_ret_i);
    dat_sum = {1'b0, dat_cnt_q} - (DAT_CR_W+1)'(dat_debit_i) + (DAT_CR_W+1)'(dat_ret_i);
    hdr_cnt_d = hdr_sum[HDR_CR_W] ? '1 : hdr_sum[HDR_CR_W-1:0];
    dat_cnt_d = dat_sum[DAT_CR_W] ? '1 : dat_sum[DAT_CR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_cnt_q <= HDR_CR_W'(HDR_INIT);
      dat_cnt_q <= DAT_CR_W'(DAT_INIT);
    end else begin
      hdr_cnt_q <= hdr_cnt_d;
      dat_cnt_q <= dat_cnt_d;
    end
  end

  assign hdr_cnt_o = hdr_cnt_q;
  assign dat_cnt_o = dat_cnt_q;

endmodule : tlp_fc_credit_counter

`default_nettype wire

// File: rtl/tlp_tx_arbiter.sv
// ============================================================================
// Module   : tlp_tx_arbiter
// Purpose  : Credit-aware transmit arbiter for posted, non-posted and
//            completion TLPs. A type is eligible when it requests and has
//            one header credit plus enough data credits. The winner is
//            granted (one-hot, registered) until the datapath reports
//            tlp_done; credits are debited on the grant edge.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req_valid_i[2:0]  - request per type (P, NP, CPL)
//            req_len_i[29:0]   - payload length in DW, 10 bits per type
//            req_has_data_i    - TLP carries payload, per type
//            tlp_done_i        - last beat of the granted TLP
//            hdr_cr_ret_i      - one header credit returned, per type
//            dat_cr_ret_i      - data credits returned, 8 bits per type
//            grant_o           - one-hot grant
//            busy_o            - a TLP is in flight
//            cr_stall_o        - type requesting but blocked by credits
// Config   : TLP_ARB_CPL_PRIO_EN - when defined, an eligible completion
//            always wins and P/NP round-robin between themselves.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlp_tx_arbiter
  import tlp_pkg::*;
#(
  parameter int HDR_CR_INIT = 32,
  parameter int DAT_CR_INIT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_TYPES-1:0]       req_valid_i,
  input  logic [NUM_TYPES*LEN_W-1:0] req_len_i,
  input  logic [NUM_TYPES-1:0]       req_has_data_i,
  input  logic                       tlp_done_i,
  input  logic [NUM_TYPES-1:0]       hdr_cr_ret_i,
  input  logic [NUM_TYPES*RET_W-1:0] dat_cr_ret_i,
  output logic [NUM_TYPES-1:0]       grant_o,
  output logic                       busy_o,
  output logic [NUM_TYPES-1:0]       cr_stall_o
);

  arb_state_e                          state_q, state_d;
  logic [NUM_TYPES-1:0]                grant_q, grant_d;
  logic                                busy_q, busy_d;
  logic [NUM_TYPES-1:0]                cr_stall_q;
  logic [1:0]                          last_q, last_d;

  logic [NUM_TYPES-1:0][HDR_CR_W-1:0]  hdr_cnt;
  logic [NUM_TYPES-1:0][DAT_CR_W-1:0]  dat_cnt;
  logic [NUM_TYPES-1:0][NEED_W-1:0]    need;
  logic [NUM_TYPES-1:0][NEED_W-1:0]    dat_debit;
  logic [NUM_TYPES-1:0]                hdr_debit;
  logic [NUM_TYPES-1:0]                eligible;
  logic [NUM_TYPES-1:0]                win;
  logic [1:0]                          win_idx;

  // --------------------------------------------------------------------------
  // Per-type credit check and counters
  // --------------------------------------------------------------------------
  for (genvar t = 0; t < NUM_TYPES; t++) begin : g_type
    assign need[t]     = data_need(req_has_data_i[t], req_len_i[LEN_W*t +: LEN_W]);
    assign eligible[t] = req_valid_i[t] && (hdr_cnt[t] != '0) &&
                         (dat_cnt[t] >= DAT_CR_W'(need[t]));

    tlp_fc_credit_counter #(
      .HDR_INIT (HDR_CR_INIT),
      .DAT_INIT (DAT_CR_INIT)
    ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .hdr_debit_i (hdr_debit[t]),
      .hdr_ret_i   (hdr_cr_ret_i[t]),
      .dat_debit_i (dat_debit[t]),
      .dat_ret_i   (dat_cr_ret_i[RET_W*t +: RET_W]),
      .hdr_cnt_o   (hdr_cnt[t]),
      .dat_cnt_o   (dat_cnt[t])
    );
  end : g_type

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
  always_comb begin
    win = '0;
`ifdef TLP_ARB_CPL_PRIO_EN
    // CPL pre-empts the rotation; P/NP rotate with CPL masked out.
    if (eligible[TLP_CPL]) begin
      win = 3'b100;
    end else begin
      win = rr_pick({1'b0, eligible[TLP_NP:TLP_P]}, last_q);
    end
`else
    win = rr_pick(eligible, last_q);
`endif
    win_idx = win[TLP_NP] ? 2'd1 : (win[TLP_CPL] ? 2'd2 : 2'd0);
  end

  // --------------------------------------------------------------------------
  // FSM next state, grant and credit debit
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    last_d    = last_q;
    hdr_debit = '0;
    dat_debit = '0;
    case (state_q)
      ST_IDLE: begin
        if (|win) begin
          state_d   = ST_GRANT;
          grant_d   = win;
          busy_d    = 1'b1;
          hdr_debit = win;
          for (int i = 0; i < NUM_TYPES; i++) begin
            dat_debit[i] = win[i] ? need[i] : '0;
          end
`ifdef TLP_ARB_CPL_PRIO_EN
          if (!win[TLP_CPL]) begin
            last_d = win_idx;
          end
`else
          last_d = win_idx;
`endif
        end
      end
      ST_GRANT: begin
        if (tlp_done_i) begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      cr_stall_q <= '0;
      last_q     <= 2'(TLP_CPL);  // search begins at P after reset
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      cr_stall_q <= req_valid_i & ~eligible;
      last_q     <= last_d;
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign cr_stall_o = cr_stall_q;

endmodule : tlp_tx_arbiter

`default_nettype wire
